// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/CTRL register window on the
// CPU data bus, a small byte FIFO, and a serialiser driving tx.
module uart_tx_mmio #(
   parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        init,
   input  logic [31:0] addr,
   input  logic        we,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   output logic        hit,
   output logic        tx,
   output logic        busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState_e;

   txState_e      state;
   logic [7:0]    fifoMem [FIFO_DEPTH];
   logic [AW-1:0] wrPtr, rdPtr;
   logic [AW:0]   count;
   logic          overflow, enable;
   logic [CW-1:0] baudCnt;
   logic [2:0]    bitIdx;
   logic [7:0]    shiftReg;
   logic          txReg;

   logic [3:0]  offset;
   logic        selTx, selStat, selCtrl;
   logic        empty, full, bitEnd, pop, pushReq, push;
   logic [31:0] statusWord;
   logic        unusedWd;

   assign offset  = addr[3:0];
   assign hit     = (addr[31:4] == BASE_ADDR[31:4]);
   assign selTx   = hit && (offset == 4'h0);
   assign selStat = hit && (offset == 4'h4);
   assign selCtrl = hit && (offset == 4'h8);

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign bitEnd  = (baudCnt == LAST_TICK);
   // Pop happens on IDLE exit or at the end of a stop bit, so frames chain without a gap.
   assign pop     = enable && !empty && ((state == IDLE) || ((state == STOP) && bitEnd));
   assign pushReq = selTx && we;
   assign push    = pushReq && (!full || pop);
   assign busy    = (state != IDLE) || !empty;
   assign tx      = txReg;
   assign unusedWd = ^wd[31:8];

   always_comb begin
      statusWord = '0;
      statusWord[0] = full;
      statusWord[1] = empty;
      statusWord[2] = busy;
      statusWord[3] = overflow;
      statusWord[8 +: AW + 1] = count;
   end

   always_comb begin
      rd = '0;
      if (selStat)      rd = statusWord;
      else if (selCtrl) rd = {31'd0, enable};
   end

   always_ff @(posedge clk) begin
      if (push) fifoMem[wrPtr] <= wd[7:0];
   end

   always_ff @(posedge clk) begin
      if (init) begin
         wrPtr    <= '0;
         rdPtr    <= '0;
         count    <= '0;
         overflow <= 1'b0;
         enable   <= 1'b1;
      end else begin
         if (push) wrPtr <= wrPtr + 1'b1;
         if (pop)  rdPtr <= rdPtr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (pushReq && full && !pop) overflow <= 1'b1;
         else if (selStat && we)      overflow <= 1'b0;
         if (selCtrl && we) enable <= wd[0];
      end
   end

   always_ff @(posedge clk) begin
      if (init) begin
         state    <= IDLE;
         baudCnt  <= '0;
         bitIdx   <= '0;
         shiftReg <= '0;
         txReg    <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               baudCnt <= '0;
               if (pop) begin
                  shiftReg <= fifoMem[rdPtr];
                  txReg    <= 1'b0;
                  state    <= START;
               end
            end
            START: begin
               if (bitEnd) begin
                  baudCnt <= '0;
                  bitIdx  <= '0;
                  txReg   <= shiftReg[0];
                  state   <= DATA;
               end else begin
                  baudCnt <= baudCnt + 1'b1;
               end
            end
            DATA: begin
               if (bitEnd) begin
                  baudCnt <= '0;
                  if (bitIdx == 3'd7) begin
                     txReg <= 1'b1;
                     state <= STOP;
                  end else begin
                     bitIdx   <= bitIdx + 1'b1;
                     shiftReg <= {1'b0, shiftReg[7:1]};
                     txReg    <= shiftReg[1];
                  end
               end else begin
                  baudCnt <= baudCnt + 1'b1;
               end
            end
            STOP: begin
               if (bitEnd) begin
                  baudCnt <= '0;
                  if (pop) begin
                     shiftReg <= fifoMem[rdPtr];
                     txReg    <= 1'b0;
                     state    <= START;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  baudCnt <= baudCnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               txReg <= 1'b1;
            end
         endcase
      end
   end

endmodule
